// File: rtl/axis_block_sig_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_block_sig_gen
// Purpose  : Qualifies sustained AXI-Stream stalls per channel into block
//            flags, plus first-blocker and peak-stall capture.
// Revision : 1.0 - initial release
// ============================================================================
module axis_block_sig_gen #(
   parameter int                NUM_CH       = 4,
   parameter logic [NUM_CH-1:0] CH_IS_OUT    = {NUM_CH{1'b0}},
   parameter int                STALL_THRESH = 16,
   parameter int                CNT_W        = 16,
   localparam int               IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              inst_idle,
   input  logic [NUM_CH-1:0] ch_tvalid,
   input  logic [NUM_CH-1:0] ch_tready,
   input  logic              clear_sticky,
   output logic [NUM_CH-1:0] axis_block_sigs,
   output logic              block_any,
   output logic              first_blk_valid,
   output logic [IDX_W-1:0]  first_blk_idx,
   output logic [CNT_W-1:0]  max_stall
);

   localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(STALL_THRESH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0]  cnt      [NUM_CH];
   logic [CNT_W-1:0]  cnt_next [NUM_CH];
   logic [NUM_CH-1:0] stall;
   logic [NUM_CH-1:0] qual;
   logic [NUM_CH-1:0] blk_next;
   logic [NUM_CH-1:0] rising;
   logic [IDX_W-1:0]  low_idx;
   logic [CNT_W-1:0]  max_next;

   always_comb begin
      stall    = '0;
      qual     = '0;
      blk_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         stall[i] = CH_IS_OUT[i] ? (ch_tvalid[i] & ~ch_tready[i])
                                 : (ch_tready[i] & ~ch_tvalid[i]);
         qual[i]  = enable & ~inst_idle & stall[i];
         if (qual[i])
            cnt_next[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + 1'b1;
         else
            cnt_next[i] = '0;
         blk_next[i] = qual[i] & (cnt[i] >= THR_M1);
      end
   end

   assign rising = blk_next & ~axis_block_sigs;

   // Descending scan so the lowest rising index is the one left standing.
   always_comb begin
      low_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (rising[i])
            low_idx = IDX_W'(i);
      end
   end

   always_comb begin
      max_next = max_stall;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cnt_next[i] > max_next)
            max_next = cnt_next[i];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++)
            cnt[i] <= '0;
         axis_block_sigs <= '0;
         block_any       <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            cnt[i] <= cnt_next[i];
         axis_block_sigs <= blk_next;
         block_any       <= |blk_next;
      end
   end

   // Clear takes priority so a flag rising in the clear cycle is not latched.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         first_blk_valid <= 1'b0;
         first_blk_idx   <= '0;
         max_stall       <= '0;
      end else if (clear_sticky) begin
         first_blk_valid <= 1'b0;
         first_blk_idx   <= '0;
         max_stall       <= '0;
      end else begin
         if (!first_blk_valid && (|rising)) begin
            first_blk_valid <= 1'b1;
            first_blk_idx   <= low_idx;
         end
         max_stall <= max_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_block_sig_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_block_sig_gen
// Purpose  : Directed + randomized bench for two axis_block_sig_gen configs
//            against a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_block_sig_gen;

   localparam int NUM_CH = 4;
   localparam logic [NUM_CH-1:0] DIRS = 4'b1110;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              inst_idle = 1'b0;
   logic [NUM_CH-1:0] ch_tvalid = '0;
   logic [NUM_CH-1:0] ch_tready = '0;
   logic              clear_sticky = 1'b0;

   logic [NUM_CH-1:0] blk_a, blk_b;
   logic              any_a, any_b, fv_a, fv_b;
   logic [1:0]        fi_a, fi_b;
   logic [15:0]       mx_a;
   logic [3:0]        mx_b;

   int vectors = 0;
   int fails   = 0;

   always #5 clock = ~clock;

   axis_block_sig_gen #(.NUM_CH(NUM_CH), .CH_IS_OUT(DIRS), .STALL_THRESH(16), .CNT_W(16)) dut_a (
      .clock(clock), .reset(reset), .enable(enable), .inst_idle(inst_idle),
      .ch_tvalid(ch_tvalid), .ch_tready(ch_tready), .clear_sticky(clear_sticky),
      .axis_block_sigs(blk_a), .block_any(any_a), .first_blk_valid(fv_a),
      .first_blk_idx(fi_a), .max_stall(mx_a));

   axis_block_sig_gen #(.NUM_CH(NUM_CH), .CH_IS_OUT(DIRS), .STALL_THRESH(15), .CNT_W(4)) dut_b (
      .clock(clock), .reset(reset), .enable(enable), .inst_idle(inst_idle),
      .ch_tvalid(ch_tvalid), .ch_tready(ch_tready), .clear_sticky(clear_sticky),
      .axis_block_sigs(blk_b), .block_any(any_b), .first_blk_valid(fv_b),
      .first_blk_idx(fi_b), .max_stall(mx_b));

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: length of the current run of qualified stall cycles.
   int thr  [2] = '{16, 15};
   int cmax [2] = '{65535, 15};
   int run  [2][NUM_CH];
   bit mflag[2][NUM_CH];
   bit mfv  [2];
   int mfi  [2];
   int mmx  [2];
   int m_peak, m_low;
   bit m_stall, m_q, m_new;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
               run[k][i]   = 0;
               mflag[k][i] = 1'b0;
            end
            mfv[k] = 1'b0;
            mfi[k] = 0;
            mmx[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_peak = mmx[k];
            m_low  = -1;
            for (int i = 0; i < NUM_CH; i++) begin
               m_stall = DIRS[i] ? (ch_tvalid[i] && !ch_tready[i])
                                 : (ch_tready[i] && !ch_tvalid[i]);
               m_q = enable && !inst_idle && m_stall;
               run[k][i] = m_q ? run[k][i] + 1 : 0;
               m_new = (run[k][i] >= thr[k]);
               if (((run[k][i] < cmax[k]) ? run[k][i] : cmax[k]) > m_peak)
                  m_peak = (run[k][i] < cmax[k]) ? run[k][i] : cmax[k];
               if (m_new && !mflag[k][i] && m_low < 0)
                  m_low = i;
               mflag[k][i] = m_new;
            end
            if (clear_sticky) begin
               mfv[k] = 1'b0;
               mfi[k] = 0;
               mmx[k] = 0;
            end else begin
               if (!mfv[k] && m_low >= 0) begin
                  mfv[k] = 1'b1;
                  mfi[k] = m_low;
               end
               mmx[k] = m_peak;
            end
         end
      end
   end

   function automatic int flags_of(input int k);
      int v = 0;
      for (int i = 0; i < NUM_CH; i++)
         if (mflag[k][i]) v |= (1 << i);
      return v;
   endfunction

   always @(negedge clock) begin
      if (!reset) begin
         chk("a.blk",  int'(blk_a), flags_of(0));
         chk("a.any",  int'(any_a), int'(flags_of(0) != 0));
         chk("a.fv",   int'(fv_a),  int'(mfv[0]));
         chk("a.fidx", int'(fi_a),  mfi[0]);
         chk("a.max",  int'(mx_a),  mmx[0]);
         chk("b.blk",  int'(blk_b), flags_of(1));
         chk("b.any",  int'(any_b), int'(flags_of(1) != 0));
         chk("b.fv",   int'(fv_b),  int'(mfv[1]));
         chk("b.fidx", int'(fi_b),  mfi[1]);
         chk("b.max",  int'(mx_b),  mmx[1]);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clock);
   endtask

   task automatic quiet_and_clear();
      ch_tvalid = '0;
      ch_tready = '0;
      inst_idle = 1'b0;
      tick(1);
      clear_sticky = 1'b1;
      tick(1);
      clear_sticky = 1'b0;
      tick(1);
   endtask

   initial begin
      tick(3);
      chk("reset.blk", int'(blk_a), 0);
      reset  = 1'b0;
      enable = 1'b1;
      tick(2);
      chk("post_reset.fv", int'(fv_a), 0);
      chk("post_reset.max", int'(mx_a), 0);

      // ch0 input stream stalling
      ch_tready[0] = 1'b1;
      tick(15);
      chk("t1.flag_at15", int'(blk_a[0]), 0);
      tick(1);
      chk("t1.flag_at16", int'(blk_a[0]), 1);
      chk("t1.any", int'(any_a), 1);
      chk("t1.fv", int'(fv_a), 1);
      chk("t1.fidx", int'(fi_a), 0);
      tick(4);
      chk("t1.hold", int'(blk_a[0]), 1);
      chk("t1.max20", int'(mx_a), 20);
      ch_tready[0] = 1'b0;
      tick(1);
      chk("t1.drop", int'(blk_a[0]), 0);
      quiet_and_clear();

      // ch2 output stream, 15-cycle stalls broken by one transfer
      ch_tvalid[2] = 1'b1;
      repeat (3) begin
         ch_tready[2] = 1'b0;
         tick(15);
         chk("t2.no_flag", int'(blk_a[2]), 0);
         ch_tready[2] = 1'b1;
         tick(1);
      end
      chk("t2.max15", int'(mx_a), 15);
      quiet_and_clear();

      // ch1 and ch3 stalling together
      ch_tvalid[1] = 1'b1;
      ch_tvalid[3] = 1'b1;
      tick(30);
      chk("t3.both", int'(blk_a), 4'b1010);
      chk("t3.fidx", int'(fi_a), 1);
      clear_sticky = 1'b1;
      tick(1);
      clear_sticky = 1'b0;
      tick(3);
      chk("t3.cleared", int'(fv_a), 0);
      ch_tready[1] = 1'b1;
      tick(1);
      ch_tready[1] = 1'b0;
      tick(10);
      chk("t3.still_none", int'(fv_a), 0);
      tick(6);
      chk("t3.recapture", int'(fv_a), 1);
      chk("t3.recap_idx", int'(fi_a), 1);
      quiet_and_clear();

      // idle interrupts a block
      ch_tready[0] = 1'b1;
      tick(20);
      inst_idle = 1'b1;
      tick(1);
      chk("t4.idle_drop", int'(blk_a[0]), 0);
      inst_idle = 1'b0;
      tick(15);
      chk("t4.re15", int'(blk_a[0]), 0);
      tick(1);
      chk("t4.re16", int'(blk_a[0]), 1);

      // async reset mid-cycle during block
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("t5.async_blk", int'(blk_a), 0);
      chk("t5.async_any", int'(any_a), 0);
      chk("t5.async_fv", int'(fv_a), 0);
      chk("t5.async_max", int'(mx_a), 0);
      chk("t5.async_b", int'(blk_b), 0);
      #1 reset = 1'b0;
      tick(1);
      tick(15);
      chk("t5.restart15", int'(blk_a[0]), 0);
      tick(1);
      chk("t5.restart16", int'(blk_a[0]), 1);
      quiet_and_clear();

      // saturation on the narrow instance, then enable drop
      ch_tready[0] = 1'b1;
      tick(40);
      chk("t6.b_flag", int'(blk_b[0]), 1);
      chk("t6.b_max", int'(mx_b), 15);
      chk("t6.a_max", int'(mx_a), 40);
      enable = 1'b0;
      tick(1);
      chk("t6.en_blk", int'(blk_a), 0);
      chk("t6.en_fv", int'(fv_b), 1);
      chk("t6.en_max", int'(mx_b), 15);
      enable = 1'b1;
      quiet_and_clear();

      // randomized: channel pairs held for random durations
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if ($urandom_range(0, 7) == 0) begin
               ch_tvalid[i] = $urandom_range(0, 1) == 1;
               ch_tready[i] = $urandom_range(0, 1) == 1;
            end
         end
         inst_idle    = ($urandom_range(0, 49) == 0);
         enable       = ($urandom_range(0, 99) != 0);
         clear_sticky = ($urandom_range(0, 59) == 0);
         tick(1);
      end
      clear_sticky = 1'b0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
`default_nettype wire
